proc_control_fsm: RTL
=====================

# proc_control_fsm

Parametrised control unit for the multi-cycle simple processor. It latches each instruction, then steps through timesteps T0–T3, plus memory wait states, to drive one-hot register strobes, ALU strobes, bus-source selects and memory handshakes for the datapath. Compared with the fixed 8-register, 4-opcode unit it replaces, it adds:
- generic register count;
- full register addressing, including the top register;
- LD, ST and MVNZ;
- configurable memory wait states;
- run sampled only at instruction start.

## Interface
Parameters:
- REG_BITS, 3, register-index width; NREGS = 2**REG_BITS; instruction width IRW = 3 + 2*REG_BITS
- MEM_WAIT, 1, wait cycles inserted in LD between address issue and data capture; legal 0..15

Ports:
- clock  in  1  single clock, rising edge
- resetn  in  1  reset; asynchronous, active-low
- run  in  1  start request, sampled only in T0
- ir  in  IRW  instruction, format III XXX YYY; opcode ir[IRW-1:IRW-3], X = ir[2*REG_BITS-1:REG_BITS], Y = ir[REG_BITS-1:0]; must be stable from the cycle after ir_in until done
- g_nz  in  1  G register nonzero flag (MVNZ condition)
- ir_in  out  1  latch instruction from din
- r_in  out  NREGS  one-hot register write enables
- r_out  out  NREGS  one-hot register bus drive
- a_in, g_in, g_out  out  1 each  ALU A latch, G latch, G bus drive
- add_sub  out  1  0 = add, 1 = subtract
- din_out  out  1  din drives bus
- addr_in, dout_in, w_d  out  1 each  address latch, data-out latch, memory write
- done  out  1  last cycle of instruction
- busy  out  1  state != T0

## Operation
- Opcodes: MV 000, MVI 001, ADD 010, SUB 011, LD 100, ST 101, MVNZ 110, NOP 111.
- All outputs are combinational decodes of state and ir. Any output not listed for a step is 0.
- At most one bus source is active per cycle: one r_out bit, din_out, or g_out.
- T0 (idle/fetch): ir_in = run. If run, go to T1; else stay in T0.
- T1:
  - MV: r_out[Y], r_in[X], done.
  - MVI: din_out, r_in[X], done.
  - ADD/SUB: r_out[X], a_in.
  - LD/ST: r_out[Y], addr_in.
  - MVNZ: if g_nz then r_out[Y] and r_in[X]; done in either case.
  - NOP: done.
- TW (LD only, entered when MEM_WAIT > 0): wait counter loads MEM_WAIT-1 on entry and decrements each cycle. No strobes. Go to T2 when the counter = 0.
- T2:
  - ADD: r_out[Y], g_in, add_sub = 0.
  - SUB: r_out[Y], g_in, add_sub = 1.
  - LD: din_out, r_in[X], done.
  - ST: r_out[X], dout_in, w_d, done.
- T3 (ADD/SUB): g_out, r_in[X], done.
- Transitions:
  - Any cycle with done returns to T0.
  - T1 goes to TW (LD with MEM_WAIT > 0) or to T2.
  - T2 goes to T3 for ADD/SUB.
- X = Y is legal (e.g. ADD R3,R3 doubles R3).
- Register index NREGS-1 is fully addressable.
- Reset: asynchronous entry to T0, wait counter = 0. While resetn = 0, every output is forced to 0, including ir_in and busy. Reset mid-instruction abandons it with no further strobes.

## Timing
- Instruction latency from the T0 cycle with run = 1 to done, inclusive:
  - MV / MVI / MVNZ / NOP: 2 cycles.
  - ST: 3 cycles.
  - ADD / SUB: 4 cycles.
  - LD: 3 + MEM_WAIT cycles.
- run deasserted after T0 does not stall or abort the instruction.
- run held high issues back-to-back instructions: the cycle after done is T0, with ir_in asserted again.
- g_nz is sampled in the T1 cycle of MVNZ only.
- The first rising edge after resetn deasserts evaluates T0.

## Test plan
- Reset mid-ADD: assert resetn = 0 during T2 -> all outputs 0 immediately. After release with run = 0: state T0, busy = 0, no strobes.
- MV R7,R2 (REG_BITS = 3, ir = 000_111_010) -> T1: r_out = 8'h04, r_in = 8'h80, done = 1. Next cycle busy = 0.
- SUB R1,R5 -> T1: r_out = 8'h02, a_in. T2: r_out = 8'h20, g_in, add_sub = 1. T3: g_out, r_in = 8'h02, done. Total 4 cycles.
- LD R4,[R6] with MEM_WAIT = 2 -> addr_in with r_out = 8'h40, then 2 idle cycles, then din_out, r_in = 8'h10, done. Total 5 cycles. Repeat with MEM_WAIT = 0 -> 3 cycles.
- MVNZ R0,R3 with g_nz = 0 -> done in T1 and r_in = 0. With g_nz = 1 -> r_out = 8'h08, r_in = 8'h01.
- run held high across ST then MVI, REG_BITS = 4 -> ST: w_d and dout_in in its T2 cycle. Next cycle T0 with ir_in = 1. MVI completes 2 cycles later. r_in is 16 bits wide and at most one bit of r_in/r_out is high in any cycle.

Source files
------------

// File: rtl/proc_control_fsm.sv
// Control unit for the multi-cycle processor: sequences T0/T1/TW/T2/T3 and decodes datapath strobes.
// Latency: 2 cycles MV/MVI/MVNZ/NOP, 3 ST, 4 ADD/SUB, 3+MEM_WAIT LD (T0 with run through done).
// No backpressure: run is only looked at in T0; once started an instruction always completes.
module proc_control_fsm #(
  parameter  int REG_BITS = 3,
  parameter  int MEM_WAIT = 1,
  localparam int NREGS    = 2**REG_BITS,
  localparam int IRW      = 3 + 2*REG_BITS
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             run,
  input  logic [IRW-1:0]   ir,
  input  logic             g_nz,
  output logic             ir_in,
  output logic [NREGS-1:0] r_in,
  output logic [NREGS-1:0] r_out,
  output logic             a_in,
  output logic             g_in,
  output logic             g_out,
  output logic             add_sub,
  output logic             din_out,
  output logic             addr_in,
  output logic             dout_in,
  output logic             w_d,
  output logic             done,
  output logic             busy
);

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  // TW runs MEM_WAIT cycles: the counter starts at MEM_WAIT-1 and leaves on zero.
  localparam int         WAIT_INIT_I = (MEM_WAIT > 0) ? MEM_WAIT - 1 : 0;
  localparam logic [3:0] WAIT_INIT   = WAIT_INIT_I[3:0];

  typedef enum logic [2:0] {ST_T0, ST_T1, ST_TW, ST_T2, ST_T3} state_t;

  state_t              state, state_nxt;
  logic   [3:0]        wait_cnt, wait_cnt_nxt;
  logic   [2:0]        op;
  logic   [REG_BITS-1:0] rx, ry;

  assign op = ir[IRW-1 -: 3];
  assign rx = ir[2*REG_BITS-1 -: REG_BITS];
  assign ry = ir[REG_BITS-1:0];

  // State and wait counter registers; reset parks the sequencer in T0.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_T0;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next-state selection from the current timestep and opcode.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_T0: if (run) state_nxt = ST_T1;
      ST_T1: begin
        case (op)
          OP_MV, OP_MVI, OP_MVNZ, OP_NOP: state_nxt = ST_T0;
          OP_LD: begin
            if (MEM_WAIT > 0) begin
              state_nxt    = ST_TW;
              wait_cnt_nxt = WAIT_INIT;
            end else begin
              state_nxt = ST_T2;
            end
          end
          default: state_nxt = ST_T2;
        endcase
      end
      ST_TW: begin
        if (wait_cnt == 4'd0) state_nxt = ST_T2;
        else                  wait_cnt_nxt = wait_cnt - 4'd1;
      end
      ST_T2: state_nxt = (op == OP_ADD || op == OP_SUB) ? ST_T3 : ST_T0;
      ST_T3: state_nxt = ST_T0;
      default: state_nxt = ST_T0;
    endcase
  end

  // Strobe decode; everything is held low while reset is asserted.
  always_comb begin
    ir_in   = 1'b0;
    r_in    = '0;
    r_out   = '0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    g_out   = 1'b0;
    add_sub = 1'b0;
    din_out = 1'b0;
    addr_in = 1'b0;
    dout_in = 1'b0;
    w_d     = 1'b0;
    done    = 1'b0;
    busy    = 1'b0;
    if (resetn) begin
      busy = (state != ST_T0);
      case (state)
        ST_T0: ir_in = run;
        ST_T1: begin
          case (op)
            OP_MV:   begin r_out[ry] = 1'b1; r_in[rx] = 1'b1; done = 1'b1; end
            OP_MVI:  begin din_out = 1'b1; r_in[rx] = 1'b1; done = 1'b1; end
            OP_ADD,
            OP_SUB:  begin r_out[rx] = 1'b1; a_in = 1'b1; end
            OP_LD,
            OP_ST:   begin r_out[ry] = 1'b1; addr_in = 1'b1; end
            OP_MVNZ: begin
              if (g_nz) begin
                r_out[ry] = 1'b1;
                r_in[rx]  = 1'b1;
              end
              done = 1'b1;
            end
            OP_NOP:  done = 1'b1;
            default: done = 1'b1;
          endcase
        end
        ST_T2: begin
          case (op)
            OP_ADD:  begin r_out[ry] = 1'b1; g_in = 1'b1; end
            OP_SUB:  begin r_out[ry] = 1'b1; g_in = 1'b1; add_sub = 1'b1; end
            OP_LD:   begin din_out = 1'b1; r_in[rx] = 1'b1; done = 1'b1; end
            OP_ST:   begin r_out[rx] = 1'b1; dout_in = 1'b1; w_d = 1'b1; done = 1'b1; end
            default: done = 1'b0;
          endcase
        end
        ST_T3: begin g_out = 1'b1; r_in[rx] = 1'b1; done = 1'b1; end
        default: busy = busy;
      endcase
    end
  end

endmodule
